// File: rtl/karat_seq_ctrl_pkg.sv
// Shared widths and state encoding for the sequential Karatsuba multiplier.
package karat_seq_ctrl_pkg;

    localparam int N     = 16;
    localparam int H     = N / 2;
    localparam int MID_W = 2 * H + 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MUL_LL  = 3'd1,
        ST_MUL_HH  = 3'd2,
        ST_MUL_MID = 3'd3,
        ST_COMBINE = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/karat_seq_ctrl_if.sv
// Operand/result handshake bundle between producer, multiplier and consumer.
interface karat_seq_ctrl_if;
    import karat_seq_ctrl_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     X;
    logic [N-1:0]     Y;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   XY;
    logic             busy;

    modport master (
        output in_valid, X, Y, out_ready,
        input  in_ready, out_valid, XY, busy
    );

    modport slave (
        input  in_valid, X, Y, out_ready,
        output in_ready, out_valid, XY, busy
    );

endinterface

// File: rtl/karat_16.sv
// 8x8 unsigned multiplier built as partial products summed by a balanced adder tree.
module karat_16
    import karat_seq_ctrl_pkg::*;
(
    input  logic [H-1:0]   a_i,
    input  logic [H-1:0]   b_i,
    output logic [2*H-1:0] p_o
);

    logic [2*H-1:0] pp_s [8];
    logic [2*H-1:0] l1_s [4];
    logic [2*H-1:0] l2_s [2];

    // Partial products and three tree levels
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            if (b_i[i]) begin
                pp_s[i] = {{H{1'b0}}, a_i} << i;
            end else begin
                pp_s[i] = {(2*H){1'b0}};
            end
        end
        for (int i = 0; i < 4; i++) begin
            l1_s[i] = pp_s[2*i] + pp_s[2*i+1];
        end
        for (int i = 0; i < 2; i++) begin
            l2_s[i] = l1_s[2*i] + l1_s[2*i+1];
        end
        p_o = l2_s[0] + l2_s[1];
    end

endmodule

// File: rtl/karat_seq_ctrl.sv
// 16x16 Karatsuba multiplier sharing one 8x8 multiplier across LL, HH and MID;
// one product in flight, result held in XY until the next COMBINE.
module karat_seq_ctrl
    import karat_seq_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    karat_seq_ctrl_if.slave bus
);

    state_e             state_q, state_d;
    logic [N-1:0]       x_q, y_q;
    logic [H-1:0]       sl_q, tl_q;
    logic               cx_q, cy_q;
    logic [2*H-1:0]     ll_q, hh_q;
    logic [MID_W-1:0]   mid_q;
    logic [2*N-1:0]     xy_q;
    logic               in_ready_q, out_valid_q, busy_q;

    logic               accept_s;
    logic [H:0]         sx_s, sy_s;
    logic [H-1:0]       mul_a_s, mul_b_s;
    logic [2*H-1:0]     prod_s;
    logic [MID_W-1:0]   mid_d, mid_diff_s;
    logic [2*N-1:0]     xy_d;

    assign accept_s = bus.in_valid & in_ready_q;
    assign sx_s     = {1'b0, bus.X[H-1:0]} + {1'b0, bus.X[N-1:H]};
    assign sy_s     = {1'b0, bus.Y[H-1:0]} + {1'b0, bus.Y[N-1:H]};

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_MUL_LL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL_LL:  state_d = ST_MUL_HH;
            ST_MUL_HH:  state_d = ST_MUL_MID;
            ST_MUL_MID: state_d = ST_COMBINE;
            ST_COMBINE: state_d = ST_DONE;
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Operand select for the single shared multiplier
    always_comb begin
        mul_a_s = {H{1'b0}};
        mul_b_s = {H{1'b0}};
        case (state_q)
            ST_MUL_LL: begin
                mul_a_s = x_q[H-1:0];
                mul_b_s = y_q[H-1:0];
            end
            ST_MUL_HH: begin
                mul_a_s = x_q[N-1:H];
                mul_b_s = y_q[N-1:H];
            end
            ST_MUL_MID: begin
                mul_a_s = sl_q;
                mul_b_s = tl_q;
            end
            default: begin
                mul_a_s = {H{1'b0}};
                mul_b_s = {H{1'b0}};
            end
        endcase
    end

    karat_16 u_mul (
        .a_i (mul_a_s),
        .b_i (mul_b_s),
        .p_o (prod_s)
    );

    // The dropped 9th bits of the half sums re-enter here as shifted corrections
    assign mid_d = {2'b00, prod_s}
                 + (cx_q ? {2'b00, tl_q, {H{1'b0}}} : {MID_W{1'b0}})
                 + (cy_q ? {2'b00, sl_q, {H{1'b0}}} : {MID_W{1'b0}})
                 + {1'b0, cx_q & cy_q, {(2*H){1'b0}}};

    assign mid_diff_s = mid_q - {2'b00, hh_q} - {2'b00, ll_q};
    assign xy_d = {hh_q, {(2*H){1'b0}}}
                + ({{(2*N-MID_W){1'b0}}, mid_diff_s} << H)
                + {{(2*N-2*H){1'b0}}, ll_q};

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            x_q         <= {N{1'b0}};
            y_q         <= {N{1'b0}};
            sl_q        <= {H{1'b0}};
            tl_q        <= {H{1'b0}};
            cx_q        <= 1'b0;
            cy_q        <= 1'b0;
            ll_q        <= {(2*H){1'b0}};
            hh_q        <= {(2*H){1'b0}};
            mid_q       <= {MID_W{1'b0}};
            xy_q        <= {(2*N){1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        x_q  <= bus.X;
                        y_q  <= bus.Y;
                        sl_q <= sx_s[H-1:0];
                        cx_q <= sx_s[H];
                        tl_q <= sy_s[H-1:0];
                        cy_q <= sy_s[H];
                    end
                end
                ST_MUL_LL:  ll_q  <= prod_s;
                ST_MUL_HH:  hh_q  <= prod_s;
                ST_MUL_MID: mid_q <= mid_d;
                ST_COMBINE: xy_q  <= xy_d;
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.XY        = xy_q;

endmodule

// File: tb/tb_karat_seq_ctrl.sv
// Directed and randomised checks of karat_seq_ctrl against a plain X*Y product queue.
module tb_karat_seq_ctrl;

    logic clk;
    logic rst_n;

    karat_seq_ctrl_if bus_if ();

    karat_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_acc = 0;
    int          n_hs  = 0;
    logic [31:0] ref_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // One full transaction; optionally offers a second operand pair while stalled in DONE.
    task automatic do_txn(input logic [15:0] x, input logic [15:0] y, input int stall,
                          input bit poke, input logic [15:0] x2, input logic [15:0] y2);
        int          waitc;
        int          lat;
        logic [31:0] exp_v;
        logic [31:0] held;
        waitc = 0;
        while (bus_if.in_ready !== 1'b1 && waitc < 20) begin
            step();
            waitc++;
        end
        chk("in_ready_wait", {31'h0, bus_if.in_ready}, 32'h1);
        bus_if.in_valid  = 1'b1;
        bus_if.X         = x;
        bus_if.Y         = y;
        bus_if.out_ready = (stall == 0);
        ref_q.push_back({16'h0, x} * {16'h0, y});
        n_acc++;
        step();
        bus_if.in_valid = 1'b0;
        bus_if.X        = 16'($urandom);
        bus_if.Y        = 16'($urandom);
        // latency counted in edges, the accepting edge being the first
        lat = 1;
        while (bus_if.out_valid !== 1'b1 && lat < 20) begin
            chk("busy_run", {31'h0, bus_if.busy}, 32'h1);
            chk("in_ready_run", {31'h0, bus_if.in_ready}, 32'h0);
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'd5);
        chk("busy_done", {31'h0, bus_if.busy}, 32'h1);
        exp_v = (ref_q.size() > 0) ? ref_q.pop_front() : 32'hDEAD_BEEF;
        chk("XY", bus_if.XY, exp_v);
        n_hs++;
        held = bus_if.XY;
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                bus_if.in_valid = 1'b1;
                bus_if.X        = x2;
                bus_if.Y        = y2;
            end
            step();
            chk("hold_valid", {31'h0, bus_if.out_valid}, 32'h1);
            chk("hold_XY", bus_if.XY, held);
            chk("hold_in_ready", {31'h0, bus_if.in_ready}, 32'h0);
        end
        bus_if.out_ready = 1'b1;
        step();
        bus_if.out_ready = 1'b0;
        chk("post_valid", {31'h0, bus_if.out_valid}, 32'h0);
        chk("post_in_ready", {31'h0, bus_if.in_ready}, 32'h1);
        chk("post_busy", {31'h0, bus_if.busy}, 32'h0);
        chk("post_XY", bus_if.XY, held);
    endtask

    initial begin
        logic [15:0] rx;
        logic [15:0] ry;
        bus_if.in_valid  = 1'b0;
        bus_if.X         = 16'h0000;
        bus_if.Y         = 16'h0000;
        bus_if.out_ready = 1'b0;
        rst_n            = 1'b0;
        step();
        step();
        chk("rst_out_valid", {31'h0, bus_if.out_valid}, 32'h0);
        chk("rst_busy", {31'h0, bus_if.busy}, 32'h0);
        chk("rst_XY", bus_if.XY, 32'h0);
        chk("rst_in_ready", {31'h0, bus_if.in_ready}, 32'h1);
        rst_n = 1'b1;
        step();

        do_txn(16'h1234, 16'h5678, 0, 1'b0, 16'h0, 16'h0);
        do_txn(16'hFFFF, 16'hFFFF, 0, 1'b0, 16'h0, 16'h0);
        do_txn(16'h8080, 16'h8080, 0, 1'b0, 16'h0, 16'h0);
        do_txn(16'h0000, 16'hABCD, 0, 1'b0, 16'h0, 16'h0);
        do_txn(16'h0001, 16'hFFFF, 0, 1'b0, 16'h0, 16'h0);

        // Backpressure, with a second pair offered during the stall
        do_txn(16'h00FF, 16'h0100, 10, 1'b1, 16'hBEEF, 16'h1357);
        do_txn(16'hBEEF, 16'h1357, 0, 1'b0, 16'h0, 16'h0);

        // Reset while in MUL_MID discards the product
        bus_if.in_valid = 1'b1;
        bus_if.X        = 16'hFFFF;
        bus_if.Y        = 16'hFFFF;
        step();
        bus_if.in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_valid", {31'h0, bus_if.out_valid}, 32'h0);
        chk("midrst_busy", {31'h0, bus_if.busy}, 32'h0);
        chk("midrst_XY", bus_if.XY, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("midrst_quiet", {31'h0, bus_if.out_valid}, 32'h0);
        end
        do_txn(16'h0100, 16'h0100, 0, 1'b0, 16'h0, 16'h0);

        for (int t = 0; t < 1000; t++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            if ((t % 50) == 0) rx = 16'hFFFF;
            if ((t % 70) == 0) ry = 16'h8080;
            do_txn(rx, ry, int'($urandom_range(0, 3)), 1'b0, 16'h0, 16'h0);
        end

        chk("handshakes", 32'(n_hs), 32'(n_acc));
        chk("queue_empty", 32'(ref_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
